// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the PC fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] HALT_INSTR       = 32'h0000_0000;
    localparam logic [7:0]  DEFAULT_RESET_PC = 8'h00;
    localparam int          PC_STEP          = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_wait_timer.sv
// ============================================================================
// Module      : fetch_wait_timer
// Description : 8-bit wait counter; expired flags the cycle it would hit MAX_WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] c_LAST = 8'(MAX_WAIT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Combinational so the FSM can leave FETCH on the very cycle the count reaches MAX_WAIT.
    assign expired = enable && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter owner and instruction-memory fetch handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted,
    output logic               timeout_err,
    output logic               misalign_err,
    output logic [15:0]        retired_count
);

    localparam int c_ALIGN_BITS = $clog2(PC_STEP);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic               r_timeout_err;
    logic               r_misalign_err;
    logic [15:0]        r_retired;

    logic w_fetch;
    logic w_hold;
    logic w_is_halt;
    logic w_load;
    logic w_expired;
    logic w_timeout;
    logic w_accept;
    logic w_misalign;

    assign w_fetch    = (r_state == FETCH);
    assign w_hold     = (r_state == HOLD);
    assign w_is_halt  = (imem_rdata == INSTR_W'(HALT_INSTR));
    assign w_load     = w_fetch && imem_valid && !w_is_halt;
    assign w_timeout  = w_fetch && !imem_valid && w_expired;
    assign w_accept   = w_hold && instr_ready;
    assign w_misalign = |next_pc[c_ALIGN_BITS-1:0];

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_fetch && imem_valid),
        .enable  (w_fetch && !imem_valid),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  w_next_state = FETCH;
            FETCH: begin
                if (imem_valid) begin
                    w_next_state = w_is_halt ? HALT : HOLD;
                end else if (w_expired) begin
                    w_next_state = HALT;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    w_next_state = w_misalign ? HALT : FETCH;
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_instr        <= '0;
            r_instr_valid  <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_retired      <= 16'd0;
        end else begin
            if (w_load) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            // A misaligned target still retires the current instruction but never reaches pc.
            if (w_accept) begin
                r_instr_valid <= 1'b0;
                if (r_retired != 16'hFFFF) begin
                    r_retired <= r_retired + 16'd1;
                end
                if (w_misalign) begin
                    r_misalign_err <= 1'b1;
                end else begin
                    r_pc <= next_pc;
                end
            end
        end
    end

    assign pc            = r_pc;
    assign imem_addr     = r_pc;
    assign imem_req      = w_fetch;
    assign instr         = r_instr;
    assign instr_valid   = r_instr_valid;
    assign halted        = (r_state == HALT);
    assign timeout_err   = r_timeout_err;
    assign misalign_err  = r_misalign_err;
    assign retired_count = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc;
    logic [7:0]  next_pc = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;
    logic        timeout_err;
    logic        misalign_err;
    logic [15:0] retired_count;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural PC and number of retired instructions.
    logic [7:0] m_pc;
    int         m_retired;

    pc_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (32),
        .RESET_PC (8'h00),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .next_pc       (next_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .halted        (halted),
        .timeout_err   (timeout_err),
        .misalign_err  (misalign_err),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        next_pc     = 8'h00;
        step();
        step();
        reset     = 1'b0;
        m_pc      = 8'h00;
        m_retired = 0;
    endtask

    // Memory holds off for wait_n FETCH cycles, then returns d for one cycle.
    task automatic mem_respond(input int wait_n, input logic [31:0] d);
        imem_valid = 1'b0;
        repeat (wait_n) step();
        imem_valid = 1'b1;
        imem_rdata = d;
        step();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic accept(input logic [7:0] np);
        next_pc     = np;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        if (np[1:0] == 2'b00) m_pc = np;
        m_retired++;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({imem_req, instr_valid, halted, timeout_err, misalign_err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {imem_req, instr_valid, halted, timeout_err, misalign_err}); end
        checks++; if (pc !== 8'h00 || instr !== 32'h0 || retired_count !== 16'd0) begin errors++; $display("FAIL reset_values got pc=%h instr=%h ret=%0d exp 00/0/0", pc, instr, retired_count); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL req_rise got req=%b addr=%h exp 1/00", imem_req, imem_addr); end
    endtask

    task automatic test_basic();
        mem_respond(1, 32'h0050_0093);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || imem_req !== 1'b0) begin errors++; $display("FAIL basic_load got v=%b instr=%h req=%b exp 1/00500093/0", instr_valid, instr, imem_req); end
        accept(8'h04);
        checks++; if (pc !== m_pc || retired_count !== 16'(m_retired)) begin errors++; $display("FAIL basic_accept got pc=%h ret=%0d exp %h/%0d", pc, retired_count, m_pc, m_retired); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_refetch got req=%b addr=%h v=%b exp 1/04/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_branch();
        mem_respond(0, 32'h1111_0001);
        accept(8'h10);
        mem_respond(0, 32'h2222_0002);
        checks++; if (pc !== 8'h10) begin errors++; $display("FAIL branch_pre got pc=%h exp 10", pc); end
        accept(8'h30);
        checks++; if (pc !== 8'h30 || imem_addr !== 8'h30 || imem_req !== 1'b1) begin errors++; $display("FAIL branch_target got pc=%h addr=%h req=%b exp 30/30/1", pc, imem_addr, imem_req); end
    endtask

    task automatic test_backpressure();
        mem_respond(0, 32'hDEAD_BEEF);
        next_pc = 8'h40;
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'b1;
            imem_rdata = $urandom;
            step();
            checks++; if (instr !== 32'hDEAD_BEEF || pc !== 8'h30 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL backpressure_hold got instr=%h pc=%h v=%b req=%b exp deadbeef/30/1/0", instr, pc, instr_valid, imem_req); end
        end
        imem_valid = 1'b0;
        accept(8'h40);
        checks++; if (pc !== 8'h40 || retired_count !== 16'(m_retired)) begin errors++; $display("FAIL backpressure_accept got pc=%h ret=%0d exp 40/%0d", pc, retired_count, m_retired); end
    endtask

    task automatic test_timeout();
        do_reset();
        step();
        imem_valid = 1'b0;
        repeat (MAX_WAIT - 1) step();
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL timeout_early got halted=%b req=%b exp 0/1", halted, imem_req); end
        step();
        checks++; if (halted !== 1'b1 || timeout_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL timeout_fire got halted=%b terr=%b req=%b exp 1/1/0", halted, timeout_err, imem_req); end
        do_reset();
        step();
        mem_respond(MAX_WAIT - 1, 32'h1234_5678);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || timeout_err !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL timeout_edge got v=%b instr=%h terr=%b halted=%b exp 1/12345678/0/0", instr_valid, instr, timeout_err, halted); end
    endtask

    task automatic test_halt();
        do_reset();
        step();
        mem_respond(2, 32'h0);
        checks++; if (halted !== 1'b1 || timeout_err !== 1'b0 || misalign_err !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_instr got h=%b t=%b m=%b req=%b v=%b exp 1/0/0/0/0", halted, timeout_err, misalign_err, imem_req, instr_valid); end
        imem_valid = 1'b1;
        imem_rdata = 32'hABCD_0001;
        instr_ready = 1'b1;
        next_pc = 8'h08;
        repeat (3) step();
        imem_valid = 1'b0;
        instr_ready = 1'b0;
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h00 || retired_count !== 16'd0) begin errors++; $display("FAIL halt_sticky got h=%b req=%b v=%b pc=%h ret=%0d exp 1/0/0/00/0", halted, imem_req, instr_valid, pc, retired_count); end
    endtask

    task automatic test_misalign();
        do_reset();
        step();
        mem_respond(0, 32'h0000_0013);
        accept(8'h06);
        checks++; if (misalign_err !== 1'b1 || halted !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL misalign_flags got m=%b h=%b t=%b exp 1/1/0", misalign_err, halted, timeout_err); end
        checks++; if (pc !== m_pc || retired_count !== 16'(m_retired) || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL misalign_state got pc=%h ret=%0d v=%b req=%b exp %h/%0d/0/0", pc, retired_count, instr_valid, imem_req, m_pc, m_retired); end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        mem_respond(0, 32'h0000_0001);
        accept(8'hFC);
        mem_respond(0, 32'h0000_0002);
        accept(8'h00);
        checks++; if (pc !== 8'h00 || imem_addr !== 8'h00 || imem_req !== 1'b1 || misalign_err !== 1'b0 || retired_count !== 16'd2) begin errors++; $display("FAIL wrap got pc=%h addr=%h req=%b m=%b ret=%0d exp 00/00/1/0/2", pc, imem_addr, imem_req, misalign_err, retired_count); end
    endtask

    task automatic test_reset_mid();
        mem_respond(0, 32'h0000_0003);
        accept(8'h24);
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 8'h00 || retired_count !== 16'd0) begin errors++; $display("FAIL reset_mid_fetch got req=%b pc=%h ret=%0d exp 0/00/0", imem_req, pc, retired_count); end
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        reset = 1'b0;
        step();
        imem_valid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || instr !== 32'h0) begin errors++; $display("FAIL late_valid got v=%b req=%b instr=%h exp 0/1/0", instr_valid, imem_req, instr); end
        mem_respond(0, 32'h7777_0007);
        reset = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL reset_mid_hold got v=%b instr=%h exp 0/0", instr_valid, instr); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0]  np;
        int          w;
        int          bp;
        do_reset();
        step();
        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(0, MAX_WAIT - 1);
            d = $urandom;
            if (d == 32'h0) d = 32'h1;
            np = 8'($urandom) & 8'hFC;
            checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin errors++; $display("FAIL rand_req n=%0d got req=%b addr=%h exp 1/%h", n, imem_req, imem_addr, m_pc); end
            mem_respond(w, d);
            checks++; if (instr_valid !== 1'b1 || instr !== d || pc !== m_pc) begin errors++; $display("FAIL rand_load n=%0d got v=%b instr=%h pc=%h exp 1/%h/%h", n, instr_valid, instr, pc, d, m_pc); end
            bp = $urandom_range(0, 3);
            for (int k = 0; k < bp; k++) begin
                next_pc = 8'($urandom);
                step();
            end
            if (bp > 0) begin
                checks++; if (instr_valid !== 1'b1 || instr !== d || imem_req !== 1'b0) begin errors++; $display("FAIL rand_hold n=%0d got v=%b instr=%h req=%b exp 1/%h/0", n, instr_valid, instr, imem_req, d); end
            end
            accept(np);
            checks++; if (pc !== m_pc || retired_count !== 16'(m_retired)) begin errors++; $display("FAIL rand_accept n=%0d got pc=%h ret=%0d exp %h/%0d", n, pc, retired_count, m_pc, m_retired); end
        end
        checks++; if (halted !== 1'b0 || timeout_err !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rand_flags got h=%b t=%b m=%b exp 0/0/0", halted, timeout_err, misalign_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_backpressure();
        test_timeout();
        test_halt();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
